// File: rtl/lsu_riscv_pkg.sv
// Shared LSU types: FSM state encoding, LDST size codes and lane/alignment helpers.
// Stores use only B/H/W. BU/HU are treated like B/H, and any unlisted code is treated as a word.
package lsu_riscv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } lsu_state_t;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   function automatic logic lsu_is_byte(input logic [2:0] size);
      return (size == LDST_B) || (size == LDST_BU);
   endfunction

   function automatic logic lsu_is_half(input logic [2:0] size);
      return (size == LDST_H) || (size == LDST_HU);
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
      if (lsu_is_byte(size)) return 1'b0;
      if (lsu_is_half(size)) return off[0];
      return off != 2'b00;
   endfunction

   function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
      if (lsu_is_byte(size)) return 4'b0001 << off;
      if (lsu_is_half(size)) return 4'b0011 << {off[1], 1'b0};
      return 4'b1111;
   endfunction

   function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] data);
      if (lsu_is_byte(size)) return {4{data[7:0]}};
      if (lsu_is_half(size)) return {2{data[15:0]}};
      return data;
   endfunction

endpackage

// File: rtl/lsu_load_ext_riscv.sv
// Load lane select plus sign/zero extension; purely combinational.
module lsu_load_ext_riscv
   import lsu_riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  size_i,
   input  logic [1:0]  offset_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      case (size_i)
         LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: data_o = {24'd0, byte_sel};
         LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
         LDST_HU: data_o = {16'd0, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_riscv.sv
// RISC-V load/store unit: IDLE issues straight from the live inputs, REQ holds the captured request until grant.
// WAIT waits for rvalid. Stall covers every cycle before completion, so the best case is 2 cycles with 1 stall.
module lsu_riscv
   import lsu_riscv_pkg::*;
(
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_stall_req_o,
   output logic        lsu_misalign_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   lsu_state_t  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        misalign;
   logic        issue;
   logic        complete;
   logic [31:0] load_data;

   assign misalign = lsu_req_i & lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);
   // Qualifying with arstn_i keeps every request output low while reset is held.
   assign issue    = arstn_i & lsu_req_i & ~misalign & (state_q == IDLE);
   assign complete = arstn_i & (state_q == WAIT) & data_rvalid_i;

   assign lsu_misalign_o  = misalign;
   assign lsu_stall_req_o = arstn_i & lsu_req_i & ~misalign & ~complete;
   assign lsu_data_o      = (complete & ~we_q) ? load_data : 32'd0;

   lsu_load_ext_riscv u_load_ext (
      .rdata_i  (data_rdata_i),
      .size_i   (size_q),
      .offset_i (addr_q[1:0]),
      .data_o   (load_data)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      data_req_o   = 1'b0;
      data_we_o    = 1'b0;
      data_be_o    = 4'b0000;
      data_addr_o  = 32'd0;
      data_wdata_o = 32'd0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d      = data_gnt_i ? WAIT : REQ;
               we_d         = lsu_we_i;
               size_d       = lsu_size_i;
               addr_d       = lsu_addr_i;
               wdata_d      = lsu_data_i;
               data_req_o   = 1'b1;
               data_we_o    = lsu_we_i;
               data_be_o    = lsu_be(lsu_size_i, lsu_addr_i[1:0]);
               data_addr_o  = {lsu_addr_i[31:2], 2'b00};
               data_wdata_o = lsu_wdata(lsu_size_i, lsu_data_i);
            end
         end
         REQ: begin
            data_req_o   = 1'b1;
            data_we_o    = we_q;
            data_be_o    = lsu_be(size_q, addr_q[1:0]);
            data_addr_o  = {addr_q[31:2], 2'b00};
            data_wdata_o = lsu_wdata(size_q, wdata_q);
            if (data_gnt_i) state_d = WAIT;
         end
         WAIT: begin
            if (data_rvalid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_riscv.sv
// Self-checking bench for lsu_riscv: directed scenarios followed by randomized transactions against an arithmetic model.
module tb_lsu_riscv;
   import lsu_riscv_pkg::*;

   logic        clk = 1'b0;
   logic        arstn_i;
   logic        lsu_req_i, lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i, lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_req_o, lsu_misalign_o;
   logic        data_req_o, data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic        data_gnt_i, data_rvalid_i;
   logic [31:0] data_rdata_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_riscv dut (
      .clk_i           (clk),
      .arstn_i         (arstn_i),
      .lsu_req_i       (lsu_req_i),
      .lsu_we_i        (lsu_we_i),
      .lsu_size_i      (lsu_size_i),
      .lsu_addr_i      (lsu_addr_i),
      .lsu_data_i      (lsu_data_i),
      .lsu_data_o      (lsu_data_o),
      .lsu_stall_req_o (lsu_stall_req_o),
      .lsu_misalign_o  (lsu_misalign_o),
      .data_req_o      (data_req_o),
      .data_we_o       (data_we_o),
      .data_be_o       (data_be_o),
      .data_addr_o     (data_addr_o),
      .data_wdata_o    (data_wdata_o),
      .data_gnt_i      (data_gnt_i),
      .data_rvalid_i   (data_rvalid_i),
      .data_rdata_i    (data_rdata_i)
   );

   // Reference model: an access is n bytes wide and must start on an n-byte boundary.
   function automatic int nbytes(input logic [2:0] s);
      if (s == 3'd0 || s == 3'd4) return 1;
      if (s == 3'd1 || s == 3'd5) return 2;
      return 4;
   endfunction

   function automatic bit m_mis(input logic [2:0] s, input logic [31:0] a);
      return (a % nbytes(s)) != 0;
   endfunction

   function automatic logic [31:0] m_be(input logic [2:0] s, input logic [31:0] a);
      int n = nbytes(s);
      int lane = int'(a % 4) / n * n;
      return 32'(((1 << n) - 1) << lane);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] d);
      int n = nbytes(s);
      if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] r);
      int n = nbytes(s);
      int lane = int'(a % 4) / n * n;
      logic [31:0] v;
      if (n == 4) return r;
      v = (r >> (8 * lane)) & ((32'd1 << (8 * n)) - 1);
      if (s < 3'd4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One aligned access: grant after d REQ cycles, then rv extra WAIT cycles before rvalid.
   task automatic txn(input logic we, input logic [2:0] s, input logic [31:0] a,
                      input logic [31:0] d_in, input logic [31:0] rdata, input int d, input int rv);
      int stalls = 0;
      @(negedge clk);
      lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = s; lsu_addr_i = a; lsu_data_i = d_in;
      data_gnt_i = (d == 0); data_rvalid_i = 1'b0;
      #1;
      chk("issue_req", 32'(data_req_o), 32'd1);
      chk("issue_we", 32'(data_we_o), 32'(we));
      chk("issue_be", 32'(data_be_o), m_be(s, a));
      chk("issue_addr", data_addr_o, a & ~32'd3);
      chk("issue_wdata", data_wdata_o, m_wdata(s, d_in));
      chk("issue_misalign", 32'(lsu_misalign_o), 32'd0);
      stalls += int'(lsu_stall_req_o);
      for (int k = 1; k <= d; k++) begin
         @(negedge clk);
         lsu_data_i = $urandom;
         lsu_addr_i = a ^ (32'($urandom_range(1, 255)) << 4);
         data_gnt_i = (k == d);
         data_rvalid_i = 1'($urandom_range(0, 1));
         #1;
         chk("req_hold_req", 32'(data_req_o), 32'd1);
         chk("req_hold_we", 32'(data_we_o), 32'(we));
         chk("req_hold_be", 32'(data_be_o), m_be(s, a));
         chk("req_hold_addr", data_addr_o, a & ~32'd3);
         chk("req_hold_wdata", data_wdata_o, m_wdata(s, d_in));
         chk("req_lsu_data", lsu_data_o, 32'd0);
         stalls += int'(lsu_stall_req_o);
      end
      for (int k = 0; k < rv; k++) begin
         @(negedge clk);
         data_gnt_i = 1'($urandom_range(0, 1)); data_rvalid_i = 1'b0;
         #1;
         chk("wait_req", 32'(data_req_o), 32'd0);
         chk("wait_lsu_data", lsu_data_o, 32'd0);
         stalls += int'(lsu_stall_req_o);
      end
      @(negedge clk);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rdata;
      #1;
      chk("done_req", 32'(data_req_o), 32'd0);
      chk("done_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("done_data", lsu_data_o, we ? 32'd0 : m_load(s, a, rdata));
      chk("stall_cycles", 32'(stalls), 32'(1 + d + rv));
      @(negedge clk);
      lsu_req_i = 1'b0; data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
      #1;
      chk("idle_req", 32'(data_req_o), 32'd0);
      chk("idle_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("idle_data", lsu_data_o, 32'd0);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
   endtask

   task automatic mis(input logic [2:0] s, input logic [31:0] a);
      @(negedge clk);
      lsu_req_i = 1'b1; lsu_we_i = 1'($urandom_range(0, 1)); lsu_size_i = s; lsu_addr_i = a;
      data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
      #1;
      chk("mis_flag", 32'(lsu_misalign_o), 32'd1);
      chk("mis_req", 32'(data_req_o), 32'd0);
      chk("mis_stall", 32'(lsu_stall_req_o), 32'd0);
      @(negedge clk);
      #1;
      chk("mis_req_2", 32'(data_req_o), 32'd0);
      lsu_req_i = 1'b0; data_gnt_i = 1'b0;
   endtask

   initial begin
      arstn_i = 1'b0;
      lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = LDST_W; lsu_addr_i = 32'h100;
      lsu_data_i = 32'hDEAD_BEEF; data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
      #3;
      chk("rst_req", 32'(data_req_o), 32'd0);
      chk("rst_we", 32'(data_we_o), 32'd0);
      chk("rst_be", 32'(data_be_o), 32'd0);
      chk("rst_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("rst_data", lsu_data_o, 32'd0);
      @(negedge clk);
      arstn_i = 1'b1; lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;

      txn(1'b0, LDST_B, 32'h103, 32'h0, 32'h80AA_BBCC, 0, 0);
      txn(1'b1, LDST_H, 32'h202, 32'h1234_ABCD, 32'h0, 3, 0);
      mis(LDST_W, 32'h106);
      txn(1'b0, LDST_HU, 32'h2, 32'h0, 32'hF00D_0000, 1, 1);
      txn(1'b0, LDST_H, 32'h2, 32'h0, 32'hF00D_0000, 0, 0);
      txn(1'b0, 3'd6, 32'h40, 32'h0, 32'hCAFE_F00D, 0, 0);
      txn(1'b1, LDST_B, 32'h7, 32'h0000_005A, 32'h0, 2, 2);

      // Reset while the access sits in WAIT, then a late rvalid.
      @(negedge clk);
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h300;
      data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
      #1;
      chk("r43_issue", 32'(data_req_o), 32'd1);
      @(negedge clk);
      data_gnt_i = 1'b0;
      #1;
      chk("r43_wait_stall", 32'(lsu_stall_req_o), 32'd1);
      arstn_i = 1'b0;
      #1;
      chk("r43_rst_req", 32'(data_req_o), 32'd0);
      chk("r43_rst_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("r43_rst_be", 32'(data_be_o), 32'd0);
      @(negedge clk);
      arstn_i = 1'b1; lsu_req_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
      #1;
      chk("r43_late_data", lsu_data_o, 32'd0);
      chk("r43_late_stall", 32'(lsu_stall_req_o), 32'd0);
      @(negedge clk);
      data_rvalid_i = 1'b0;
      txn(1'b0, LDST_BU, 32'h401, 32'h0, 32'h0000_9900, 1, 0);

      // Flush: request drops while in WAIT, access still completes.
      @(negedge clk);
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h500;
      data_gnt_i = 1'b1;
      @(negedge clk);
      lsu_req_i = 1'b0; data_gnt_i = 1'b0;
      #1;
      chk("flush_stall", 32'(lsu_stall_req_o), 32'd0);
      chk("flush_req", 32'(data_req_o), 32'd0);
      @(negedge clk);
      data_rvalid_i = 1'b1;
      @(negedge clk);
      data_rvalid_i = 1'b0;
      txn(1'b1, LDST_W, 32'h600, 32'hA5A5_0F0F, 32'h0, 1, 0);

      for (int i = 0; i < 60; i++) begin
         logic [2:0]  s = 3'($urandom_range(0, 7));
         logic [31:0] a = $urandom;
         if (m_mis(s, a)) mis(s, a);
         else txn(1'($urandom_range(0, 1)), s, a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
